regwr_arbiter: RTL and testbench
================================

# regwr_arbiter

Write-port arbiter and scheduler for the 8x8 register file. It shares the file's single write port (WRITE/INADDRESS/IN) between two writeback sources: the ALU result path and the data-memory load path. Each source gets a one-entry holding slot with valid/ready handshake, and the arbiter grants the port round-robin. It also exports a per-register pending-write scoreboard so decode can detect read-after-write hazards.

## Interface
- DATA_W, 8, data width of one register
- ADDR_W, 3, register address width
- NREG, 8, number of registers (2**ADDR_W)

- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  synchronous, active-high
- ALU_VALID  in  1  ALU writeback request
- ALU_ADDR  in  ADDR_W  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_READY  out  1  ALU slot can accept this cycle
- MEM_VALID  in  1  load writeback request
- MEM_ADDR  in  ADDR_W  load destination register
- MEM_DATA  in  DATA_W  load data
- MEM_READY  out  1  MEM slot can accept this cycle
- RF_WRITE  out  1  register-file write enable (registered)
- RF_INADDRESS  out  ADDR_W  register-file write address (registered)
- RF_IN  out  DATA_W  register-file write data (registered)
- PENDING  out  NREG  bit a = write to register a accepted, not yet committed
- BUSY  out  1  any slot full or RF_WRITE high

## Operation
- Reset: both slots empty; RF_WRITE=0, RF_INADDRESS=0, RF_IN=0; round-robin pointer = "MEM last", so ALU wins the first tie. Outputs after reset: PENDING=0, BUSY=0. While RESET=1, ALU_READY=MEM_READY=0.
- Accept: a handshake occurs at posedge when X_VALID && X_READY. The slot captures address and data.
- X_READY = !RESET && (slot empty || slot granted this cycle). A full slot being drained accepts a new entry on the same edge, giving no bubble.
- Grant (combinational, per cycle): no slot full → no grant. One slot full → that slot. Both full → the slot opposite the pointer. The pointer updates to the granted source on each grant.
- Issue: at the posedge following a grant, RF_WRITE<=1, RF_INADDRESS<=slot addr, RF_IN<=slot data, and the slot clears unless it refills on the same edge. With no grant, RF_WRITE<=0 and RF_INADDRESS/RF_IN hold.
- States (output stage): IDLE (RF_WRITE=0) and ISSUE (RF_WRITE=1). IDLE→ISSUE on grant. ISSUE→ISSUE on grant. ISSUE→IDLE on no grant. Any state→IDLE on RESET.
- Same-address ordering:
  - Entries in different slots commit in grant order.
  - If both sources are accepted on the same edge with the same address, the ALU entry is granted first regardless of the pointer. MEM data is therefore the final value. The pointer then resumes normally.
- PENDING[a] = (ALU slot full && addr==a) || (MEM slot full && addr==a) || (RF_WRITE && RF_INADDRESS==a). This is combinational from registered state.
- Reset mid-operation: slot contents and any in-flight RF_WRITE are discarded. RF_WRITE is 0 after the reset edge. The register file resets on the same edge.

## Timing
- Accept at edge N; grant is visible in cycle N..N+1; RF_WRITE is high in cycle N+1..N+2. The register file commits at edge N+2 (its own 1-unit write delay applies).
- Minimum latency from handshake to commit is 2 cycles. With both sources streaming, each source sustains one write per 2 cycles. The port sustains one write per cycle.
- PENDING rises in the cycle after the accept edge. It falls in the cycle after the last RF_WRITE cycle for that address.
- No combinational path from X_VALID to X_READY. X_READY depends only on slot state and the grant.

## Structure
- Package regwr_pkg: DATA_W, ADDR_W, NREG constants; source encoding SRC_ALU=1'b0, SRC_MEM=1'b1; output-stage state encoding IDLE/ISSUE.
- Sub-module regwr_slot: one-entry holding buffer (full flag, addr, data; load/clear inputs, ready output), instantiated twice.
- The top level holds the arbiter, pointer, output registers and PENDING decode.

## Test plan
- Reset: RESET high for 2 edges during an active write → RF_WRITE=0, PENDING=8'h00, both READY=0 while RESET=1 and 1 after.
- Single ALU write: ALU addr 3, data 8'h5A, valid one cycle → RF_WRITE high exactly one cycle, 2 edges later, with RF_INADDRESS=3, RF_IN=8'h5A. PENDING[3] is high for 2 cycles.
- Same-cycle conflict: ALU (1, 8'h11) and MEM (2, 8'h22) accepted together → writes to 1 then 2 on consecutive cycles. MEM_READY is 0 for one cycle.
- Round-robin fairness: both VALID held high with incrementing data for 8 cycles → grants alternate ALU, MEM, ALU, … and each source retires 4 writes.
- Same address: ALU (5, 8'hAA) and MEM (5, 8'hBB) accepted together → RF_IN=8'hAA then 8'hBB. PENDING[5] stays high until the second write completes.
- Back-to-back ALU stream, MEM idle: data 1,2,3 on consecutive cycles → ALU_READY stays 1, RF_WRITE stays high 3 consecutive cycles, no bubble.

Source files
------------

// File: rtl/regwr_arbiter_pkg.sv
// regwr_pkg: shared constants and encodings for the register-file write-port
// arbiter (regwr_arbiter) and its holding slots (regwr_slot).
package regwr_pkg;

   localparam int DATA_W = 8;            // width of one register
   localparam int ADDR_W = 3;            // register address width
   localparam int NREG   = 1 << ADDR_W;  // number of registers

   // Writeback source; the round-robin pointer stores the last granted one.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   // Output stage: ISSUE means RF_WRITE is high this cycle.
   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } ostate_e;

endpackage

// File: rtl/regwr_arbiter_slot.sv
// regwr_slot: one-entry holding buffer for a writeback source.
//   CLK, RESET   clock, synchronous active-high reset
//   i_load       capture i_addr/i_data (caller has seen valid && ready)
//   i_clear      entry is granted this cycle and leaves at the next edge
//   i_addr/data  incoming destination register and value
//   o_ready      slot can take an entry this cycle
//   o_full       slot holds an entry
//   o_addr/data  held entry
module regwr_slot
   import regwr_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   // A slot being drained this cycle can refill on the same edge.
   assign o_ready = !RESET && (!r_full || i_clear);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_full <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_addr <= i_addr;
         r_data <= i_data;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: shares the register file's single write port between the
// ALU writeback path and the load writeback path.
//   CLK, RESET                   clock, synchronous active-high reset
//   i_alu_valid/addr/data        ALU writeback request, o_alu_ready handshake
//   i_mem_valid/addr/data        load writeback request, o_mem_ready handshake
//   o_rf_write/inaddress/in      registered write port to the register file
//   o_pending[a]                 write to register a accepted, not yet committed
//   o_busy                       any slot full or a write in flight
module regwr_arbiter
   import regwr_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              i_alu_valid,
   input  logic [ADDR_W-1:0] i_alu_addr,
   input  logic [DATA_W-1:0] i_alu_data,
   output logic              o_alu_ready,
   input  logic              i_mem_valid,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic              o_mem_ready,
   output logic              o_rf_write,
   output logic [ADDR_W-1:0] o_rf_inaddress,
   output logic [DATA_W-1:0] o_rf_in,
   output logic [NREG-1:0]   o_pending,
   output logic              o_busy
);

   logic              w_alu_ready, w_alu_load, w_alu_full, w_alu_gnt;
   logic [ADDR_W-1:0] w_alu_addr;
   logic [DATA_W-1:0] w_alu_data;
   logic              w_mem_ready, w_mem_load, w_mem_full, w_mem_gnt;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_data;

   logic              w_gnt_vld;
   src_e              w_gnt_src;
   src_e              r_ptr;
   logic              r_alu_first;
   ostate_e           r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_rf_addr;
   logic [DATA_W-1:0] r_rf_data;

   assign w_alu_load = i_alu_valid && w_alu_ready;
   assign w_mem_load = i_mem_valid && w_mem_ready;

   regwr_slot u_alu_slot (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_load  (w_alu_load),
      .i_clear (w_alu_gnt),
      .i_addr  (i_alu_addr),
      .i_data  (i_alu_data),
      .o_ready (w_alu_ready),
      .o_full  (w_alu_full),
      .o_addr  (w_alu_addr),
      .o_data  (w_alu_data)
   );

   regwr_slot u_mem_slot (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_load  (w_mem_load),
      .i_clear (w_mem_gnt),
      .i_addr  (i_mem_addr),
      .i_data  (i_mem_data),
      .o_ready (w_mem_ready),
      .o_full  (w_mem_full),
      .o_addr  (w_mem_addr),
      .o_data  (w_mem_data)
   );

   // Grant depends only on slot state and pointer, so READY never sees VALID.
   // r_alu_first overrides the pointer when both sources landed the same
   // address on the same edge: ALU commits first, load data is final.
   always_comb begin
      w_gnt_vld = w_alu_full || w_mem_full;
      w_gnt_src = SRC_ALU;
      if (w_alu_full && w_mem_full)
         w_gnt_src = (r_alu_first || r_ptr == SRC_MEM) ? SRC_ALU : SRC_MEM;
      else if (w_mem_full)
         w_gnt_src = SRC_MEM;
   end

   assign w_alu_gnt = w_gnt_vld && (w_gnt_src == SRC_ALU);
   assign w_mem_gnt = w_gnt_vld && (w_gnt_src == SRC_MEM);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ptr       <= SRC_MEM;
         r_alu_first <= 1'b0;
      end else begin
         if (w_gnt_vld)
            r_ptr <= w_gnt_src;
         if (w_alu_load && w_mem_load && (i_alu_addr == i_mem_addr))
            r_alu_first <= 1'b1;
         else if (w_alu_gnt)
            r_alu_first <= 1'b0;
      end
   end

   // Output stage FSM.
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_vld)  w_state_nxt = ISSUE;
         ISSUE:   if (!w_gnt_vld) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address/data hold their last value between writes.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else if (w_gnt_vld) begin
         r_rf_addr <= (w_gnt_src == SRC_ALU) ? w_alu_addr : w_mem_addr;
         r_rf_data <= (w_gnt_src == SRC_ALU) ? w_alu_data : w_mem_data;
      end
   end

   assign o_rf_write     = (r_state == ISSUE);
   assign o_rf_inaddress = r_rf_addr;
   assign o_rf_in        = r_rf_data;
   assign o_alu_ready    = w_alu_ready;
   assign o_mem_ready    = w_mem_ready;

   always_comb begin
      o_pending = '0;
      for (int a = 0; a < NREG; a++)
         o_pending[a] = (w_alu_full && w_alu_addr == ADDR_W'(a)) ||
                        (w_mem_full && w_mem_addr == ADDR_W'(a)) ||
                        (o_rf_write && r_rf_addr == ADDR_W'(a));
   end

   assign o_busy = w_alu_full || w_mem_full || o_rf_write;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: table-driven per-cycle vectors for READY/RF_WRITE/
// PENDING/BUSY, a write-port scoreboard fed in expected commit order, and
// hand-written sequences for pointer, fairness and reset corner cases.
module tb_regwr_arbiter;
   import regwr_pkg::*;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              i_alu_valid, i_mem_valid;
   logic [ADDR_W-1:0] i_alu_addr, i_mem_addr;
   logic [DATA_W-1:0] i_alu_data, i_mem_data;
   logic              o_alu_ready, o_mem_ready, o_rf_write, o_busy;
   logic [ADDR_W-1:0] o_rf_inaddress;
   logic [DATA_W-1:0] o_rf_in;
   logic [NREG-1:0]   o_pending;

   int checks = 0;
   int errors = 0;
   logic [ADDR_W+DATA_W-1:0] sb_q[$];

   regwr_arbiter dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .i_alu_valid    (i_alu_valid),
      .i_alu_addr     (i_alu_addr),
      .i_alu_data     (i_alu_data),
      .o_alu_ready    (o_alu_ready),
      .i_mem_valid    (i_mem_valid),
      .i_mem_addr     (i_mem_addr),
      .i_mem_data     (i_mem_data),
      .o_mem_ready    (o_mem_ready),
      .o_rf_write     (o_rf_write),
      .o_rf_inaddress (o_rf_inaddress),
      .o_rf_in        (o_rf_in),
      .o_pending      (o_pending),
      .o_busy         (o_busy)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string            name;
      logic             av;
      logic [2:0]       aa;
      logic [7:0]       ad;
      logic             mv;
      logic [2:0]       ma;
      logic [7:0]       md;
      logic             ear, emr, ewr;
      logic [7:0]       epd;
      logic             ebs;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string n, logic av, logic [2:0] aa, logic [7:0] ad,
                               logic mv, logic [2:0] ma, logic [7:0] md,
                               logic ear, logic emr, logic ewr, logic [7:0] epd,
                               logic ebs);
      vec_t v;
      v.name = n; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
      v.ear = ear; v.emr = emr; v.ewr = ewr; v.epd = epd; v.ebs = ebs;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      i_alu_valid = 1'b0; i_alu_addr = '0; i_alu_data = '0;
      i_mem_valid = 1'b0; i_mem_addr = '0; i_mem_data = '0;
   endtask

   // Drive one cycle of a vector, queue accepted entries (ALU before MEM),
   // compare the cycle's outputs, then advance past the next edge.
   task automatic apply(input vec_t v, input bit sb);
      i_alu_valid = v.av; i_alu_addr = v.aa; i_alu_data = v.ad;
      i_mem_valid = v.mv; i_mem_addr = v.ma; i_mem_data = v.md;
      if (sb && v.av && v.ear) sb_q.push_back({v.aa, v.ad});
      if (sb && v.mv && v.emr) sb_q.push_back({v.ma, v.md});
      #1;
      chk({v.name, ".alu_ready"}, o_alu_ready, v.ear);
      chk({v.name, ".mem_ready"}, o_mem_ready, v.emr);
      chk({v.name, ".rf_write"},  o_rf_write,  v.ewr);
      chk({v.name, ".pending"},   o_pending,   v.epd);
      chk({v.name, ".busy"},      o_busy,      v.ebs);
      @(posedge CLK);
      #1;
   endtask

   // Every committed write must match the head of the expected-order queue.
   always @(negedge CLK) begin
      if (!RESET && o_rf_write) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got write %0h<=%0h expected none", o_rf_inaddress, o_rf_in);
         end else begin
            logic [ADDR_W+DATA_W-1:0] e;
            e = sb_q.pop_front();
            chk("sb_write", {o_rf_inaddress, o_rf_in}, e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // conflict: different addresses, pointer = MEM after reset -> ALU first
      tbl.push_back(mk("cf0", 1,1,8'h11, 1,2,8'h22, 1,1,0,8'h00,0));
      tbl.push_back(mk("cf1", 0,0,0,     0,0,0,     1,0,0,8'h06,1));
      tbl.push_back(mk("cf2", 0,0,0,     0,0,0,     1,1,1,8'h06,1));
      tbl.push_back(mk("cf3", 0,0,0,     0,0,0,     1,1,1,8'h04,1));
      tbl.push_back(mk("cf4", 0,0,0,     0,0,0,     1,1,0,8'h00,0));
      // single ALU write; leaves pointer = ALU
      tbl.push_back(mk("sa0", 1,3,8'h5A, 0,0,0,     1,1,0,8'h00,0));
      tbl.push_back(mk("sa1", 0,0,0,     0,0,0,     1,1,0,8'h08,1));
      tbl.push_back(mk("sa2", 0,0,0,     0,0,0,     1,1,1,8'h08,1));
      tbl.push_back(mk("sa3", 0,0,0,     0,0,0,     1,1,0,8'h00,0));
      // same address with pointer = ALU: ALU must still commit first
      tbl.push_back(mk("sm0", 1,5,8'hAA, 1,5,8'hBB, 1,1,0,8'h00,0));
      tbl.push_back(mk("sm1", 0,0,0,     0,0,0,     1,0,0,8'h20,1));
      tbl.push_back(mk("sm2", 0,0,0,     0,0,0,     1,1,1,8'h20,1));
      tbl.push_back(mk("sm3", 0,0,0,     0,0,0,     1,1,1,8'h20,1));
      tbl.push_back(mk("sm4", 0,0,0,     0,0,0,     1,1,0,8'h00,0));
      // back-to-back ALU stream, no bubble
      tbl.push_back(mk("bb0", 1,2,8'h01, 0,0,0,     1,1,0,8'h00,0));
      tbl.push_back(mk("bb1", 1,2,8'h02, 0,0,0,     1,1,0,8'h04,1));
      tbl.push_back(mk("bb2", 1,2,8'h03, 0,0,0,     1,1,1,8'h04,1));
      tbl.push_back(mk("bb3", 0,0,0,     0,0,0,     1,1,1,8'h04,1));
      tbl.push_back(mk("bb4", 0,0,0,     0,0,0,     1,1,1,8'h04,1));
      tbl.push_back(mk("bb5", 0,0,0,     0,0,0,     1,1,0,8'h00,0));

      // reset
      RESET = 1'b1;
      idle_inputs();
      step();
      #1;
      chk("rst.alu_ready", o_alu_ready, 1'b0);
      chk("rst.mem_ready", o_mem_ready, 1'b0);
      step();
      chk("rst.rf_write",  o_rf_write, 1'b0);
      chk("rst.pending",   o_pending, 8'h00);
      chk("rst.busy",      o_busy, 1'b0);
      chk("rst.inaddress", o_rf_inaddress, 3'd0);
      chk("rst.in",        o_rf_in, 8'h00);
      RESET = 1'b0;

      foreach (tbl[i]) apply(tbl[i], 1'b1);

      // address/data hold after the last write
      chk("hold.inaddress", o_rf_inaddress, 3'd2);
      chk("hold.in",        o_rf_in, 8'h03);

      // pointer = ALU, different addresses: MEM wins the tie
      i_alu_valid = 1'b1; i_alu_addr = 3'd6; i_alu_data = 8'h66;
      i_mem_valid = 1'b1; i_mem_addr = 3'd4; i_mem_data = 8'h44;
      sb_q.push_back({3'd4, 8'h44});
      sb_q.push_back({3'd6, 8'h66});
      #1;
      chk("ptr0.alu_ready", o_alu_ready, 1'b1);
      chk("ptr0.mem_ready", o_mem_ready, 1'b1);
      step();
      idle_inputs();
      #1;
      chk("ptr1.alu_ready", o_alu_ready, 1'b0);
      chk("ptr1.mem_ready", o_mem_ready, 1'b1);
      chk("ptr1.pending",   o_pending, 8'h50);
      repeat (4) step();
      chk("ptr.idle", o_busy, 1'b0);

      // single MEM write; leaves pointer = MEM
      apply(mk("sl0", 0,0,0, 1,1,8'hC3, 1,1,0,8'h00,0), 1'b1);
      apply(mk("sl1", 0,0,0, 0,0,0,     1,1,0,8'h02,1), 1'b1);
      apply(mk("sl2", 0,0,0, 0,0,0,     1,1,1,8'h02,1), 1'b1);
      apply(mk("sl3", 0,0,0, 0,0,0,     1,1,0,8'h00,0), 1'b1);

      // fairness: both valid for 8 cycles, grants alternate ALU, MEM, ...
      begin
         int acnt, mcnt;
         acnt = 0; mcnt = 0;
         for (int k = 0; k < 8; k++) begin
            logic ear, emr;
            ear = (k == 0) || (k % 2 == 1);
            emr = (k == 0) || (k % 2 == 0);
            i_alu_valid = 1'b1; i_alu_addr = 3'd0; i_alu_data = 8'(8'h10 + acnt);
            i_mem_valid = 1'b1; i_mem_addr = 3'd7; i_mem_data = 8'(8'h80 + mcnt);
            if (ear) begin sb_q.push_back({3'd0, i_alu_data}); acnt++; end
            if (emr) begin sb_q.push_back({3'd7, i_mem_data}); mcnt++; end
            #1;
            chk("rr.alu_ready", o_alu_ready, ear);
            chk("rr.mem_ready", o_mem_ready, emr);
            step();
         end
         idle_inputs();
         repeat (6) step();
         chk("rr.idle", o_busy, 1'b0);
      end

      // reset during an in-flight write with a second entry queued
      apply(mk("rm0", 1,7,8'h77, 0,0,0, 1,1,0,8'h00,0), 1'b0);
      apply(mk("rm1", 1,6,8'h12, 0,0,0, 1,1,0,8'h80,1), 1'b0);
      idle_inputs();
      RESET = 1'b1;
      #1;
      chk("rm2.alu_ready", o_alu_ready, 1'b0);
      chk("rm2.mem_ready", o_mem_ready, 1'b0);
      step();
      chk("rm3.rf_write",  o_rf_write, 1'b0);
      chk("rm3.pending",   o_pending, 8'h00);
      chk("rm3.busy",      o_busy, 1'b0);
      chk("rm3.alu_ready", o_alu_ready, 1'b0);
      chk("rm3.inaddress", o_rf_inaddress, 3'd0);
      step();
      RESET = 1'b0;
      #1;
      chk("rm4.alu_ready", o_alu_ready, 1'b1);
      chk("rm4.mem_ready", o_mem_ready, 1'b1);
      chk("rm4.rf_write",  o_rf_write, 1'b0);
      repeat (3) step();
      chk("rm5.rf_write",  o_rf_write, 1'b0);

      chk("sb.drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
